// File: rtl/time_display_scan_if.sv
// time_display_scan_if: disp_time bus into the scanner and the multiplexed 7-segment outputs back out
interface time_display_scan_if;
  logic [23:0] disp_time;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [5:0]  an_n;
  logic        frame_end;
  modport master (output disp_time, input seg_n, dp_n, an_n, frame_end);
  modport slave (input disp_time, output seg_n, dp_n, an_n, frame_end);
endinterface

// File: rtl/time_display_scan.sv
// time_display_scan: BCD HH:MM:SS to 6-digit muxed active-low 7-seg (kh_clk, reset; bus.disp_time in; bus.seg_n/dp_n/an_n/frame_end out)
module time_display_scan #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 50,
  parameter int BLANK_LZ     = 1
) (
  input logic                 kh_clk,
  input logic                 reset,
  time_display_scan_if.slave  bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [FW-1:0] frames_q;
  logic          colon_q;
  logic [23:0]   snap_q;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    an_q, an_d;
  logic          dp_q, dp_d, fe_q;
  logic [3:0]    nib;
  logic          cnt_wrap, frame_wrap, blink;
  always_comb begin
    nib        = snap_q[{idx_q, 2'b00} +: 4];
    cnt_wrap   = cnt_q == CW'(SCAN_DIV - 1);
    frame_wrap = cnt_wrap && idx_q == 3'd5;
    blink      = frames_q == FW'(BLINK_FRAMES - 1);
    an_d = (cnt_q == '0 || (BLANK_LZ != 0 && idx_q == 3'd5 && snap_q[23:20] == 4'd0)) ? 6'h3F : ~(6'd1 << idx_q);
    dp_d = !(colon_q && (idx_q == 3'd2 || idx_q == 3'd4));
    case (nib)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b0111111;
    endcase
  end
  always_ff @(posedge kh_clk) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      frames_q <= '0;
      colon_q  <= 1'b1;
      snap_q   <= '0;
      seg_q    <= 7'h7F;
      an_q     <= 6'h3F;
      dp_q     <= 1'b1;
      fe_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_wrap ? '0 : cnt_q + 1'b1;
      idx_q <= !cnt_wrap ? idx_q : frame_wrap ? 3'd0 : idx_q + 3'd1;
      if (frame_wrap) begin
        snap_q   <= bus.disp_time;
        frames_q <= blink ? '0 : frames_q + 1'b1;
        colon_q  <= colon_q ^ blink;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
      fe_q  <= frame_wrap;
    end
  end
  assign bus.seg_n     = seg_q;
  assign bus.an_n      = an_q;
  assign bus.dp_n      = dp_q;
  assign bus.frame_end = fe_q;
endmodule

// File: tb/tb_time_display_scan.sv
// tb_time_display_scan: frame-scoreboard and vector-table bench for time_display_scan
module tb_time_display_scan;
  typedef struct {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fe;
  } exp_t;
  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    int          slot;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;
  logic kh_clk = 1'b0;
  logic reset  = 1'b1;
  time_display_scan_if bus ();
  time_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .BLANK_LZ(1)) dut (
    .kh_clk(kh_clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 kh_clk = ~kh_clk;
  exp_t q[$];
  vec_t vec[6];
  int checks = 0;
  int errors = 0;
  function automatic logic [6:0] seg_of(logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction
  function automatic bit colon_of(int f);
    return ((f / 2) % 2) == 0;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic push_frame(logic [23:0] snap, bit colon);
    for (int j = 0; j < 24; j++) begin
      exp_t e;
      int   idx;
      int   cnt;
      idx   = j / 4;
      cnt   = j % 4;
      e.an  = (cnt == 0 || (idx == 5 && snap[23:20] == 4'd0)) ? 6'h3F : 6'(~(6'd1 << idx));
      e.seg = seg_of(snap[4*idx +: 4]);
      e.dp  = !(colon && (idx == 2 || idx == 4));
      e.fe  = (j == 23);
      q.push_back(e);
    end
  endtask
  task automatic tick;
    @(posedge kh_clk);
    @(negedge kh_clk);
  endtask
  task automatic check_reset(string tag);
    chk({tag, " an_n"}, 32'(bus.an_n), 32'h3F);
    chk({tag, " seg_n"}, 32'(bus.seg_n), 32'h7F);
    chk({tag, " dp_n"}, 32'(bus.dp_n), 32'h1);
    chk({tag, " frame_end"}, 32'(bus.frame_end), 32'h0);
  endtask
  task automatic pop_check(string tag, int f, int j);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s f%0d j%0d: scoreboard empty, got an_n %0h expected an entry", tag, f, j, bus.an_n);
    end else begin
      e = q.pop_front();
      chk($sformatf("%s f%0d j%0d an_n", tag, f, j), 32'(bus.an_n), 32'(e.an));
      chk($sformatf("%s f%0d j%0d seg_n", tag, f, j), 32'(bus.seg_n), 32'(e.seg));
      chk($sformatf("%s f%0d j%0d dp_n", tag, f, j), 32'(bus.dp_n), 32'(e.dp));
      chk($sformatf("%s f%0d j%0d frame_end", tag, f, j), 32'(bus.frame_end), 32'(e.fe));
    end
  endtask
  task automatic spot(vec_t v, int f, int j);
    if (j == 4 * v.slot + 1) begin
      chk($sformatf("vec f%0d slot%0d an_n", f, v.slot), 32'(bus.an_n), 32'(v.an));
      chk($sformatf("vec f%0d slot%0d seg_n", f, v.slot), 32'(bus.seg_n), 32'(v.seg));
      chk($sformatf("vec f%0d slot%0d dp_n", f, v.slot), 32'(bus.dp_n), 32'(v.dp));
    end
  endtask
  initial begin
    vec[0] = '{24'h123456, 24'h123456, 0, 6'b111110, 7'b0000010, 1'b1};
    vec[1] = '{24'h123456, 24'h999999, 2, 6'b111011, 7'b0010000, 1'b1};
    vec[2] = '{24'h12345A, 24'h12345A, 0, 6'b111110, 7'b0111111, 1'b1};
    vec[3] = '{24'h091530, 24'h091530, 4, 6'b101111, 7'b0010000, 1'b0};
    vec[4] = '{24'h000000, 24'h000000, 5, 6'b111111, 7'b1000000, 1'b1};
    vec[5] = '{24'h777777, 24'h777777, 2, 6'b111011, 7'b1111000, 1'b1};
    bus.disp_time = 24'h0;
    reset = 1'b1;
    @(negedge kh_clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset($sformatf("reset%0d", i));
    end
    reset = 1'b0;
    bus.disp_time = vec[0].a;
    push_frame(24'h0, 1'b1);
    for (int f = 0; f < 6; f++) begin
      push_frame(vec[f].b, colon_of(f + 1));
      for (int j = 0; j < 24; j++) begin
        bus.disp_time = (j < 5) ? vec[f].a : vec[f].b;
        tick();
        pop_check("run", f, j);
        if (f > 0) spot(vec[f-1], f, j);
      end
    end
    bus.disp_time = 24'h555555;
    for (int j = 0; j < 10; j++) begin
      tick();
      pop_check("run", 6, j);
      spot(vec[5], 6, j);
    end
    reset = 1'b1;
    tick();
    check_reset("midframe");
    q.delete();
    reset = 1'b0;
    bus.disp_time = 24'h235959;
    push_frame(24'h0, 1'b1);
    push_frame(24'h235959, 1'b1);
    for (int c = 0; c < 48; c++) begin
      tick();
      pop_check("post", c / 24, c % 24);
      if (c == 9) chk("colon after reset dp_n", 32'(bus.dp_n), 32'h0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
